// File: rtl/mips16_pkg.sv
// Shared MIPS16 definitions: instruction format codes, field layout and loader states.
// The CPU field splitter uses the same field positions.
package mips16_pkg;

  typedef enum logic [1:0] {
    FMT_R   = 2'd0,
    FMT_I   = 2'd1,
    FMT_J   = 2'd2,
    FMT_ILL = 2'd3
  } fmt_e;

  localparam int OPCODE_HI = 15;
  localparam int OPCODE_LO = 13;
  localparam int RS_HI     = 12;
  localparam int RS_LO     = 10;
  localparam int RT_HI     = 9;
  localparam int RT_LO     = 7;
  localparam int RD_HI     = 6;
  localparam int RD_LO     = 4;
  localparam int FUNCT_HI  = 3;
  localparam int FUNCT_LO  = 0;
  localparam int IMM_HI    = 6;
  localparam int IMM_LO    = 0;
  localparam int TARGET_HI = 12;
  localparam int TARGET_LO = 0;

  localparam int WORD_W   = 16;
  localparam int REG_W    = 3;
  localparam int FUNCT_W  = 4;
  localparam int IMM_W    = 7;
  localparam int TARGET_W = 13;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_LOAD = 2'd1,
    ST_DONE = 2'd2
  } ld_state_e;

endpackage

// File: rtl/instr_field_packer.sv
// Combinational packer: assembles a 16-bit instruction word from decoded fields.
// Fields not used by the selected format are ignored; format 3 raises the illegal flag.
module instr_field_packer
  import mips16_pkg::*;
(
  input  logic [1:0]  fmt,
  input  logic [2:0]  opcode,
  input  logic [2:0]  rs,
  input  logic [2:0]  rt,
  input  logic [2:0]  rd,
  input  logic [3:0]  funct,
  input  logic [6:0]  imm,
  input  logic [12:0] target,
  output logic [15:0] word,
  output logic        illegal
);

  always_comb begin
    word    = '0;
    illegal = 1'b0;
    word[OPCODE_HI:OPCODE_LO] = opcode;
    case (fmt)
      FMT_R: begin
        word[RS_HI:RS_LO]       = rs;
        word[RT_HI:RT_LO]       = rt;
        word[RD_HI:RD_LO]       = rd;
        word[FUNCT_HI:FUNCT_LO] = funct;
      end
      FMT_I: begin
        word[RS_HI:RS_LO]   = rs;
        word[RT_HI:RT_LO]   = rt;
        word[IMM_HI:IMM_LO] = imm;
      end
      FMT_J: begin
        word[TARGET_HI:TARGET_LO] = target;
      end
      default: begin
        word    = '0;
        illegal = 1'b1;
      end
    endcase
  end

endmodule

// File: rtl/instr_encoder_loader.sv
// Boot loader: encodes instruction fields and streams them into instruction memory,
// holding the CPU in reset for the duration of a load session.
module instr_encoder_loader
  import mips16_pkg::*;
#(
  parameter int INST_SIZE  = 16,
  parameter int ADDR_WIDTH = 8,
  parameter int DEPTH      = 256
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [1:0]            in_fmt,
  input  logic [2:0]            in_opcode,
  input  logic [2:0]            in_rs,
  input  logic [2:0]            in_rt,
  input  logic [2:0]            in_rd,
  input  logic [3:0]            in_funct,
  input  logic [6:0]            in_imm,
  input  logic [12:0]           in_target,
  input  logic                  in_last,
  output logic                  mem_we,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  output logic [INST_SIZE-1:0]  mem_wdata,
  output logic [ADDR_WIDTH:0]   word_count,
  output logic                  busy,
  output logic                  cpu_hold,
  output logic                  done,
  output logic                  err_fmt,
  output logic                  err_overflow
);

  localparam logic [ADDR_WIDTH:0] DEPTH_C = (ADDR_WIDTH+1)'(DEPTH);

  ld_state_e             state_q, state_d;
  logic [ADDR_WIDTH:0]   count_q, count_d;
  logic                  mem_we_q, mem_we_d;
  logic [ADDR_WIDTH-1:0] mem_addr_q, mem_addr_d;
  logic [INST_SIZE-1:0]  mem_wdata_q, mem_wdata_d;
  logic                  err_fmt_q, err_fmt_d;
  logic                  err_ovf_q, err_ovf_d;

  logic [15:0] packed_word;
  logic        packed_illegal;
  logic        xfer;

  instr_field_packer u_packer (
    .fmt     (in_fmt),
    .opcode  (in_opcode),
    .rs      (in_rs),
    .rt      (in_rt),
    .rd      (in_rd),
    .funct   (in_funct),
    .imm     (in_imm),
    .target  (in_target),
    .word    (packed_word),
    .illegal (packed_illegal)
  );

  // Ready depends only on registered state so it can never combinationally track in_valid.
  assign in_ready = (state_q == ST_LOAD) && (count_q < DEPTH_C);
  assign xfer     = in_valid && in_ready;

  always_comb begin
    state_d     = state_q;
    count_d     = count_q;
    mem_we_d    = 1'b0;
    mem_addr_d  = mem_addr_q;
    mem_wdata_d = mem_wdata_q;
    err_fmt_d   = err_fmt_q;
    err_ovf_d   = err_ovf_q;
    case (state_q)
      ST_IDLE: begin
        if (start) begin
          state_d   = ST_LOAD;
          count_d   = '0;
          err_fmt_d = 1'b0;
          err_ovf_d = 1'b0;
        end
      end
      ST_LOAD: begin
        if (xfer) begin
          if (packed_illegal) begin
            err_fmt_d = 1'b1;
            if (in_last) state_d = ST_DONE;
          end else begin
            mem_we_d    = 1'b1;
            mem_addr_d  = count_q[ADDR_WIDTH-1:0];
            mem_wdata_d = packed_word;
            count_d     = count_q + 1'b1;
            if (in_last) begin
              state_d = ST_DONE;
            end else if (count_d == DEPTH_C) begin
              err_ovf_d = 1'b1;
              state_d   = ST_DONE;
            end
          end
        end
      end
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      count_q     <= '0;
      mem_we_q    <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      err_fmt_q   <= 1'b0;
      err_ovf_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      count_q     <= count_d;
      mem_we_q    <= mem_we_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
      err_fmt_q   <= err_fmt_d;
      err_ovf_q   <= err_ovf_d;
    end
  end

  assign mem_we       = mem_we_q;
  assign mem_addr     = mem_addr_q;
  assign mem_wdata    = mem_wdata_q;
  assign word_count   = count_q;
  assign busy         = (state_q == ST_LOAD);
  assign cpu_hold     = (state_q == ST_LOAD);
  assign done         = (state_q == ST_DONE);
  assign err_fmt      = err_fmt_q;
  assign err_overflow = err_ovf_q;

endmodule

// File: tb/tb_instr_encoder_loader.sv
// Directed bench for instr_encoder_loader: table of single-word sessions plus
// hand-written multi-cycle sequences (back-to-back, illegal format, overflow, reset, gaps).
module tb_instr_encoder_loader;

  logic        clk = 1'b0;
  logic        rst, start, start4, in_valid, in_last;
  logic [1:0]  in_fmt;
  logic [2:0]  in_opcode, in_rs, in_rt, in_rd;
  logic [3:0]  in_funct;
  logic [6:0]  in_imm;
  logic [12:0] in_target;

  logic        in_ready, mem_we, busy, cpu_hold, done, err_fmt, err_overflow;
  logic [7:0]  mem_addr;
  logic [15:0] mem_wdata;
  logic [8:0]  word_count;

  logic        in_ready4, mem_we4, busy4, cpu_hold4, done4, err_fmt4, err_overflow4;
  logic [7:0]  mem_addr4;
  logic [15:0] mem_wdata4;
  logic [8:0]  word_count4;

  int nchecks = 0;
  int nerrors = 0;

  always #5 clk = ~clk;

  instr_encoder_loader #(.INST_SIZE(16), .ADDR_WIDTH(8), .DEPTH(256)) dut (
    .clk(clk), .rst(rst), .start(start), .in_valid(in_valid), .in_ready(in_ready),
    .in_fmt(in_fmt), .in_opcode(in_opcode), .in_rs(in_rs), .in_rt(in_rt), .in_rd(in_rd),
    .in_funct(in_funct), .in_imm(in_imm), .in_target(in_target), .in_last(in_last),
    .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata), .word_count(word_count),
    .busy(busy), .cpu_hold(cpu_hold), .done(done), .err_fmt(err_fmt),
    .err_overflow(err_overflow)
  );

  instr_encoder_loader #(.INST_SIZE(16), .ADDR_WIDTH(8), .DEPTH(4)) dut4 (
    .clk(clk), .rst(rst), .start(start4), .in_valid(in_valid), .in_ready(in_ready4),
    .in_fmt(in_fmt), .in_opcode(in_opcode), .in_rs(in_rs), .in_rt(in_rt), .in_rd(in_rd),
    .in_funct(in_funct), .in_imm(in_imm), .in_target(in_target), .in_last(in_last),
    .mem_we(mem_we4), .mem_addr(mem_addr4), .mem_wdata(mem_wdata4), .word_count(word_count4),
    .busy(busy4), .cpu_hold(cpu_hold4), .done(done4), .err_fmt(err_fmt4),
    .err_overflow(err_overflow4)
  );

  typedef struct {
    logic [1:0]  fmt;
    logic [2:0]  op;
    logic [2:0]  rs;
    logic [2:0]  rt;
    logic [2:0]  rd;
    logic [3:0]  funct;
    logic [6:0]  imm;
    logic [12:0] tgt;
    logic        exp_we;
    logic [15:0] exp_word;
    logic [8:0]  exp_wc;
    logic        exp_err_fmt;
  } vec_t;

  vec_t vecs [8];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    nchecks++;
    if (act !== exp) begin
      nerrors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic [1:0] fmt, input logic [2:0] op, input logic [2:0] rs,
                       input logic [2:0] rt, input logic [2:0] rd, input logic [3:0] funct,
                       input logic [6:0] imm, input logic [12:0] tgt, input logic last);
    in_valid  = 1'b1;
    in_fmt    = fmt;
    in_opcode = op;
    in_rs     = rs;
    in_rt     = rt;
    in_rd     = rd;
    in_funct  = funct;
    in_imm    = imm;
    in_target = tgt;
    in_last   = last;
  endtask

  task automatic do_start();
    start = 1'b1;
    step();
    start = 1'b0;
  endtask

  initial begin
    vecs[0] = '{2'd0, 3'd0, 3'd1, 3'd2, 3'd3, 4'd5,  7'h7F, 13'h1FFF, 1'b1, 16'h0535, 9'd1, 1'b0};
    vecs[1] = '{2'd1, 3'd4, 3'd2, 3'd5, 3'd7, 4'hF,  7'h7F, 13'h1FFF, 1'b1, 16'h8AFF, 9'd1, 1'b0};
    vecs[2] = '{2'd2, 3'd7, 3'd5, 3'd5, 3'd5, 4'hF,  7'h55, 13'h0ABC, 1'b1, 16'hEABC, 9'd1, 1'b0};
    vecs[3] = '{2'd0, 3'd7, 3'd7, 3'd7, 3'd7, 4'hF,  7'h00, 13'h0000, 1'b1, 16'hFFFF, 9'd1, 1'b0};
    vecs[4] = '{2'd1, 3'd1, 3'd0, 3'd3, 3'd6, 4'h9,  7'h15, 13'h1234, 1'b1, 16'h2195, 9'd1, 1'b0};
    vecs[5] = '{2'd2, 3'd0, 3'd7, 3'd7, 3'd7, 4'hF,  7'h7F, 13'h0000, 1'b1, 16'h0000, 9'd1, 1'b0};
    vecs[6] = '{2'd3, 3'd5, 3'd1, 3'd1, 3'd1, 4'h1,  7'h01, 13'h0001, 1'b0, 16'h0000, 9'd0, 1'b1};
    vecs[7] = '{2'd0, 3'd5, 3'd4, 3'd1, 3'd6, 4'hA,  7'h00, 13'h0000, 1'b1, 16'hB0EA, 9'd1, 1'b0};

    rst = 1'b1; start = 1'b0; start4 = 1'b0;
    drive(2'd0, 3'd0, 3'd0, 3'd0, 3'd0, 4'd0, 7'd0, 13'd0, 1'b0);
    in_valid = 1'b0;
    step(); step();
    rst = 1'b0;
    chk("reset_we",     32'(mem_we), 0);
    chk("reset_addr",   32'(mem_addr), 0);
    chk("reset_wdata",  32'(mem_wdata), 0);
    chk("reset_wc",     32'(word_count), 0);
    chk("reset_flags",  32'({busy, cpu_hold, done, err_fmt, err_overflow, in_ready}), 0);

    // Single-word sessions from the table
    for (int i = 0; i < 8; i++) begin
      do_start();
      chk($sformatf("v%0d_ready", i), 32'({in_ready, busy, cpu_hold}), 32'b111);
      drive(vecs[i].fmt, vecs[i].op, vecs[i].rs, vecs[i].rt, vecs[i].rd,
            vecs[i].funct, vecs[i].imm, vecs[i].tgt, 1'b1);
      step();
      in_valid = 1'b0;
      chk($sformatf("v%0d_we", i), 32'(mem_we), 32'(vecs[i].exp_we));
      if (vecs[i].exp_we) begin
        chk($sformatf("v%0d_addr", i), 32'(mem_addr), 0);
        chk($sformatf("v%0d_wdata", i), 32'(mem_wdata), 32'(vecs[i].exp_word));
      end
      chk($sformatf("v%0d_wc", i), 32'(word_count), 32'(vecs[i].exp_wc));
      chk($sformatf("v%0d_done", i), 32'({done, busy, in_ready}), 32'b100);
      chk($sformatf("v%0d_errfmt", i), 32'(err_fmt), 32'(vecs[i].exp_err_fmt));
      step();
      chk($sformatf("v%0d_idle", i), 32'({mem_we, done, busy}), 0);
    end

    // Back-to-back I then J(last)
    do_start();
    drive(2'd1, 3'd4, 3'd2, 3'd5, 3'd0, 4'd0, 7'h7F, 13'd0, 1'b0);
    step();
    chk("b2b_w0", 32'({mem_we, mem_addr, mem_wdata}), {1'b1, 8'd0, 16'h8AFF});
    chk("b2b_wc0", 32'({word_count, busy, done}), {9'd1, 1'b1, 1'b0});
    drive(2'd2, 3'd7, 3'd0, 3'd0, 3'd0, 4'd0, 7'd0, 13'h0ABC, 1'b1);
    step();
    in_valid = 1'b0;
    chk("b2b_w1", 32'({mem_we, mem_addr, mem_wdata}), {1'b1, 8'd1, 16'hEABC});
    chk("b2b_wc1", 32'({word_count, busy, done}), {9'd2, 1'b0, 1'b1});
    step();

    // R, illegal, I(last)
    do_start();
    drive(2'd0, 3'd0, 3'd1, 3'd2, 3'd3, 4'd5, 7'd0, 13'd0, 1'b0);
    step();
    chk("ill_w0", 32'({mem_we, mem_addr, mem_wdata}), {1'b1, 8'd0, 16'h0535});
    drive(2'd3, 3'd7, 3'd7, 3'd7, 3'd7, 4'hF, 7'h7F, 13'h1FFF, 1'b0);
    step();
    chk("ill_nowrite", 32'({mem_we, err_fmt, busy}), 32'b011);
    chk("ill_wc", 32'(word_count), 1);
    drive(2'd1, 3'd4, 3'd2, 3'd5, 3'd0, 4'd0, 7'h7F, 13'd0, 1'b1);
    step();
    in_valid = 1'b0;
    chk("ill_w1", 32'({mem_we, mem_addr, mem_wdata}), {1'b1, 8'd1, 16'h8AFF});
    chk("ill_done", 32'({done, err_fmt, word_count}), {1'b1, 1'b1, 9'd2});
    step();
    chk("ill_sticky", 32'({err_fmt, done, busy}), 32'b100);
    do_start();
    chk("ill_cleared", 32'({err_fmt, busy}), 32'b01);
    drive(2'd2, 3'd1, 3'd0, 3'd0, 3'd0, 4'd0, 7'd0, 13'd5, 1'b1);
    step();
    in_valid = 1'b0;
    step();

    // Overflow on the DEPTH=4 instance
    start4 = 1'b1;
    step();
    start4 = 1'b0;
    for (int k = 0; k < 4; k++) begin
      chk($sformatf("ovf_ready%0d", k), 32'(in_ready4), 1);
      drive(2'd2, 3'd2, 3'd0, 3'd0, 3'd0, 4'd0, 7'd0, 13'(k + 16), 1'b0);
      step();
      chk($sformatf("ovf_w%0d", k), 32'({mem_we4, mem_addr4, mem_wdata4}),
          {1'b1, 8'(k), 3'd2, 13'(k + 16)});
      chk($sformatf("ovf_end%0d", k), 32'({done4, err_overflow4}), (k == 3) ? 32'b11 : 32'b00);
    end
    chk("ovf_ready_done", 32'({in_ready4, word_count4}), {1'b0, 9'd4});
    step();
    chk("ovf_fifth", 32'({mem_we4, in_ready4, word_count4, done4, err_overflow4}),
        {1'b0, 1'b0, 9'd4, 1'b0, 1'b1});
    in_valid = 1'b0;
    step();

    // Reset mid-session
    do_start();
    drive(2'd0, 3'd1, 3'd1, 3'd1, 3'd1, 4'd1, 7'd0, 13'd0, 1'b0);
    step();
    step();
    chk("rst_pre", 32'({mem_we, mem_addr, word_count}), {1'b1, 8'd1, 9'd2});
    rst = 1'b1;
    step();
    rst = 1'b0;
    chk("rst_mid_out", 32'({mem_we, mem_addr, mem_wdata, word_count}), 0);
    chk("rst_mid_flags", 32'({busy, cpu_hold, done, err_fmt, err_overflow, in_ready}), 0);
    step();
    chk("rst_held_off", 32'({mem_we, word_count, in_ready}), 0);
    in_valid = 1'b0;
    do_start();
    drive(2'd2, 3'd3, 3'd0, 3'd0, 3'd0, 4'd0, 7'd0, 13'h0042, 1'b1);
    step();
    in_valid = 1'b0;
    chk("rst_restart", 32'({mem_we, mem_addr, mem_wdata, word_count}),
        {1'b1, 8'd0, 16'h6042, 9'd1});
    step();

    // Gaps and start pulsed during LOAD
    do_start();
    drive(2'd1, 3'd2, 3'd3, 3'd4, 3'd0, 4'd0, 7'h11, 13'd0, 1'b0);
    step();
    chk("gap_w0", 32'({mem_we, mem_addr, mem_wdata}), {1'b1, 8'd0, 16'h4E11});
    in_valid = 1'b0;
    start = 1'b1;
    step();
    start = 1'b0;
    chk("gap_idle1", 32'({mem_we, word_count, busy}), {1'b0, 9'd1, 1'b1});
    step();
    chk("gap_idle2", 32'({mem_we, word_count, busy}), {1'b0, 9'd1, 1'b1});
    drive(2'd0, 3'd6, 3'd2, 3'd1, 3'd0, 4'd3, 7'd0, 13'd0, 1'b1);
    step();
    in_valid = 1'b0;
    chk("gap_w1", 32'({mem_we, mem_addr, mem_wdata}), {1'b1, 8'd1, 16'hC883});
    chk("gap_done", 32'({done, word_count}), {1'b1, 9'd2});
    step();
    chk("gap_end", 32'({done, busy, mem_we}), 0);

    $display("Simulation finished: %0d checks, %0d errors", nchecks, nerrors);
    $finish;
  end

endmodule
